uart_rx_ctrl: RTL and testbench

UART receive controller sequenced by the baud tick from the existing mod_m_counter (N=8, M=163: 16x oversampling of 19200 baud at 50 MHz).
- Synchronises the serial line, detects and validates the start bit, and shifts in DBIT data bits at mid-bit.
- Checks the stop bit, then presents the byte with a one-clock done pulse.
- Sits between the pin and the downstream byte consumer (ALU interface FSM).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 45 ++++
 rtl/uart_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared constants and types for the UART receive path.
//   - rx_state_e  : 2-bit receiver state encoding (IDLE/START/DATA/STOP)
//   - DBIT_DEFAULT / SB_TICK_DEFAULT : default frame shape (8N1)
//   - MID_BIT / BIT_END : s_tick counts for mid-start-bit and end-of-bit
//   - BAUD_N / BAUD_M   : mod_m_counter setup giving 16x oversampling of
//                         19200 baud from a 50 MHz clock
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

  // With 16 ticks per bit, tick 7 lands in the middle of the start bit and
  // tick 15 closes a full bit period, which is the middle of the next bit.
  localparam int MID_BIT = 7;
  localparam int BIT_END = 15;

  localparam int BAUD_N = 8;
  localparam int BAUD_M = 163;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser bringing an asynchronous level into the clk domain.
//   Ports:
//     clk   - system clock
//     reset - synchronous, active-high reset; both flops load RESET_VAL
//     d     - asynchronous input
//     q     - synchronised output, two clk cycles behind d
//   Parameter:
//     RESET_VAL - value both flops take on reset (1 for an idle-high line)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // The first stage may go metastable; the second stage gives it a full
  // clock period to resolve before anything downstream looks at it.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages reset to the idle level so a reset never looks like a
  // falling edge on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   UART receiver sequenced by a 16x oversampling tick. Synchronises the
//   serial line, validates the start bit at mid-bit, shifts in DBIT data
//   bits LSB first, checks the stop bit and presents the byte together with
//   a one-clock done pulse.
//   Ports:
//     clk          - system clock, all logic on the rising edge
//     reset        - synchronous, active-high reset
//     rx           - asynchronous serial line, idle high
//     s_tick       - 16x oversample enable, one clk wide
//     rx_done_tick - one-clock pulse, frame complete and dout valid
//     dout         - received data, held until the next rx_done_tick
//     frame_err    - stop bit sampled low on the last frame
//     busy         - high whenever the receiver is not idle
//   Parameters:
//     DBIT    - data bits per frame, 5..8
//     SB_TICK - s_ticks spent in the stop bit (16, 24 or 32)
// ---------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
);

  // Four bits cover a data bit; longer stop periods (1.5 or 2 stop bits)
  // need one more bit to reach SB_TICK-1.
  localparam int S_CNT_W = (SB_TICK > 16) ? 5 : 4;

  rx_state_e           state_q, state_d;
  logic [S_CNT_W-1:0]  s_cnt_q, s_cnt_d;
  logic [2:0]          n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]     shift_q, shift_d;
  logic [DBIT-1:0]     dout_q, dout_d;
  logic                frame_err_q, frame_err_d;
  logic                done_q, done_d;
  logic                rx_s;

  // The FSM only ever looks at the synchronised copy of the line.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // Next-state and datapath logic. Everything holds by default; the done
  // pulse defaults low so it can only be high for the single cycle that
  // closes a frame. Apart from leaving IDLE, nothing moves without s_tick.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A low line starts timing immediately so the tick phase does not
        // add to the start-edge uncertainty more than once.
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_CNT_W'(MID_BIT)) begin
            // Still low at mid-bit is a genuine start bit; otherwise the
            // edge was a glitch and we drop back silently.
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_CNT_W'(BIT_END)) begin
            // Sixteen ticks after a mid-bit sample is the middle of the
            // next bit. Data arrives LSB first, so shift in from the top.
            s_cnt_d = '0;
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            if (n_cnt_q == 3'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_CNT_W'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_CNT_W'(SB_TICK - 1)) begin
            // A low stop bit still delivers the byte, flagged as a
            // framing error, so a stuck-low line cannot lock us up.
            done_d      = 1'b1;
            dout_d      = shift_q;
            frame_err_d = ~rx_s;
            state_d     = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + S_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset takes priority over s_tick and
  // aborts any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  // The done pulse is registered alongside dout and frame_err, so all
  // three become visible on the same cycle and dout is already valid
  // while the pulse is high.
  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Self-checking bench for uart_rx_ctrl. A free-running divider produces
//   s_tick; frames are driven bit by bit and every rx_done_tick is logged
//   by a monitor, then compared against expectations built from the frame
//   rules (byte sent, stop level, frame length in ticks).
//   The divider runs at BAUD_M/8 so a bit is 320 clk instead of 2608; the
//   receiver only counts ticks, so the behaviour is the same, just shorter.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DBIT        = DBIT_DEFAULT;
  localparam int SB_TICK     = SB_TICK_DEFAULT;
  localparam int TB_M        = BAUD_M / 8;
  localparam int BIT_CLK     = 16 * TB_M;
  localparam int FRAME_TICKS = 8 + 16 * DBIT + SB_TICK;
  localparam int TIME_TOL    = TB_M + 3;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            rx    = 1'b1;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            busy;

  logic [BAUD_N-1:0] baud_cnt = '0;
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  logic [DBIT-1:0] got_data[$];
  logic            got_err[$];
  int              got_cyc[$];

  uart_rx_ctrl #(
    .DBIT   (DBIT),
    .SB_TICK(SB_TICK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // 100 MHz-style clock; period is irrelevant, only cycle counts matter.
  always #5 clk = ~clk;

  // Free-running mod-M divider standing in for mod_m_counter, plus a
  // cycle counter used to time done pulses.
  always @(posedge clk) begin
    baud_cnt <= (baud_cnt == BAUD_N'(TB_M - 1)) ? '0 : baud_cnt + 1'b1;
    cyc      <= cyc + 1;
  end
  assign s_tick = (baud_cnt == BAUD_N'(TB_M - 1));

  // Log every done pulse away from the active edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_data.push_back(dout);
      got_err.push_back(frame_err);
      got_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    got_data.delete();
    got_err.delete();
    got_cyc.delete();
  endtask

  task automatic send_bit(input logic b, input int nclk);
    rx = b;
    repeat (nclk) @(negedge clk);
  endtask

  // Good frames hold the stop bit high for a full bit. Bad frames hold it
  // low for three quarters of a bit and then let the line recover, which
  // keeps the receiver's post-frame false start well clear of a boundary.
  task automatic send_frame(input logic [DBIT-1:0] data, input bit stop_ok,
                            output int start_cyc);
    start_cyc = cyc;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < DBIT; i++) send_bit(data[i], BIT_CLK);
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLK);
    end else begin
      send_bit(1'b0, (BIT_CLK * 3) / 4);
      send_bit(1'b1, BIT_CLK - (BIT_CLK * 3) / 4);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (dout !== '0) begin
      failures++; $display("[TB] FAIL reset_dout: got %0h expected 0", dout);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    clear_log();
    send_bit(1'b1, 5000);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_busy: got %b expected 0", busy);
    end
    checks++;
    if (got_data.size() != 0) begin
      failures++; $display("[TB] FAIL idle_no_done: got %0d pulses expected 0", got_data.size());
    end
  endtask

  task automatic test_single();
    int st;
    int diff;
    clear_log();
    send_frame(8'hA5, 1'b1, st);
    checks++;
    if (got_data.size() != 1) begin
      failures++; $display("[TB] FAIL single_count: got %0d expected 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 8'hA5) begin
        failures++; $display("[TB] FAIL single_dout: got %0h expected a5", got_data[0]);
      end
      checks++;
      if (got_err[0] !== 1'b0) begin
        failures++; $display("[TB] FAIL single_frame_err: got %b expected 0", got_err[0]);
      end
      diff = got_cyc[0] - st - (2 + FRAME_TICKS * TB_M);
      checks++;
      if (diff > TIME_TOL || diff < -TIME_TOL) begin
        failures++; $display("[TB] FAIL single_timing: got offset %0d expected within +-%0d", diff, TIME_TOL);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st;
    logic [DBIT-1:0] exp_data[2];
    exp_data[0] = 8'h00;
    exp_data[1] = 8'hFF;
    clear_log();
    send_frame(exp_data[0], 1'b1, st);
    send_frame(exp_data[1], 1'b1, st);
    checks++;
    if (got_data.size() != 2) begin
      failures++; $display("[TB] FAIL b2b_count: got %0d expected 2", got_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_err[i] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_frame%0d: got %0h/%b expected %0h/0", i, got_data[i], got_err[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    int st;
    clear_log();
    send_frame(8'h3C, 1'b0, st);
    send_bit(1'b1, BIT_CLK / 2);
    checks++;
    if (dout !== 8'h3C || frame_err !== 1'b1) begin
      failures++; $display("[TB] FAIL ferr_hold: got %0h/%b expected 3c/1", dout, frame_err);
    end
    send_frame(8'h11, 1'b1, st);
    checks++;
    if (got_data.size() != 2) begin
      failures++; $display("[TB] FAIL ferr_count: got %0d expected 2", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 8'h3C || got_err[0] !== 1'b1) begin
        failures++; $display("[TB] FAIL ferr_bad: got %0h/%b expected 3c/1", got_data[0], got_err[0]);
      end
      checks++;
      if (got_data[1] !== 8'h11 || got_err[1] !== 1'b0) begin
        failures++; $display("[TB] FAIL ferr_recover: got %0h/%b expected 11/0", got_data[1], got_err[1]);
      end
    end
  endtask

  task automatic test_glitch();
    int waited;
    clear_log();
    send_bit(1'b0, BIT_CLK / 4);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL glitch_busy_rise: got %b expected 1", busy);
    end
    rx = 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < BIT_CLK) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL glitch_busy_fall: got %b expected 0 within %0d clk", busy, BIT_CLK);
    end
    send_bit(1'b1, BIT_CLK);
    checks++;
    if (got_data.size() != 0) begin
      failures++; $display("[TB] FAIL glitch_no_done: got %0d pulses expected 0", got_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int st;
    logic [DBIT-1:0] partial;
    partial = 8'h55;
    clear_log();
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) send_bit(partial[i], BIT_CLK);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout !== '0 || frame_err !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_state: got busy=%b dout=%0h ferr=%b expected 0/0/0", busy, dout, frame_err);
    end
    send_bit(1'b1, 2 * BIT_CLK);
    checks++;
    if (got_data.size() != 0) begin
      failures++; $display("[TB] FAIL mid_reset_no_done: got %0d pulses expected 0", got_data.size());
    end
    send_frame(8'h5A, 1'b1, st);
    checks++;
    if (got_data.size() != 1) begin
      failures++; $display("[TB] FAIL mid_reset_count: got %0d expected 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 8'h5A || got_err[0] !== 1'b0) begin
        failures++; $display("[TB] FAIL mid_reset_next: got %0h/%b expected 5a/0", got_data[0], got_err[0]);
      end
    end
  endtask

  // Line held low for hold_ticks: every full frame period yields a zero
  // byte with a framing error; the frame in flight at release sees a low
  // data bit wherever its mid-bit sample falls before the release.
  task automatic test_break();
    int hold_ticks;
    int n_full;
    int rel;
    logic [DBIT-1:0] last_data;
    logic            last_err;
    hold_ticks = 2 * FRAME_TICKS + FRAME_TICKS / 2;
    n_full     = hold_ticks / FRAME_TICKS;
    rel        = hold_ticks - n_full * FRAME_TICKS;
    for (int i = 0; i < DBIT; i++) last_data[i] = ((8 + 16 * (i + 1)) >= rel);
    last_err = !(FRAME_TICKS >= rel);
    clear_log();
    send_bit(1'b0, hold_ticks * TB_M);
    send_bit(1'b1, 6 * BIT_CLK);
    checks++;
    if (got_data.size() != n_full + 1) begin
      failures++; $display("[TB] FAIL break_count: got %0d expected %0d", got_data.size(), n_full + 1);
    end else begin
      for (int i = 0; i < n_full; i++) begin
        checks++;
        if (got_data[i] !== '0 || got_err[i] !== 1'b1) begin
          failures++; $display("[TB] FAIL break_frame%0d: got %0h/%b expected 0/1", i, got_data[i], got_err[i]);
        end
      end
      checks++;
      if (got_data[n_full] !== last_data || got_err[n_full] !== last_err) begin
        failures++;
        $display("[TB] FAIL break_release: got %0h/%b expected %0h/%b", got_data[n_full], got_err[n_full], last_data, last_err);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL break_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_random();
    logic [DBIT-1:0] exp_data[$];
    logic            exp_err[$];
    int              starts[$];
    logic [DBIT-1:0] b;
    bit              ok;
    int              st;
    int              gap;
    int              diff;
    clear_log();
    for (int f = 0; f < 5; f++) begin
      b   = DBIT'($urandom_range(0, (1 << DBIT) - 1));
      ok  = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, st);
      exp_data.push_back(b);
      exp_err.push_back(!ok);
      starts.push_back(st);
      gap = ok ? $urandom_range(0, BIT_CLK) : BIT_CLK / 2 + $urandom_range(0, BIT_CLK);
      send_bit(1'b1, gap);
    end
    send_bit(1'b1, 4);
    checks++;
    if (got_data.size() != exp_data.size()) begin
      failures++; $display("[TB] FAIL rand_count: got %0d expected %0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_err[i] !== exp_err[i]) begin
          failures++;
          $display("[TB] FAIL rand_frame%0d: got %0h/%b expected %0h/%b", i, got_data[i], got_err[i], exp_data[i], exp_err[i]);
        end
        diff = got_cyc[i] - starts[i] - (2 + FRAME_TICKS * TB_M);
        checks++;
        if (diff > TIME_TOL || diff < -TIME_TOL) begin
          failures++; $display("[TB] FAIL rand_timing%0d: got offset %0d expected within +-%0d", i, diff, TIME_TOL);
        end
      end
    end
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("[TB] starting, bit period %0d clk", BIT_CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_break();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
